id_alu_issue: RTL
=================

# id_alu_issue

Decode-and-issue stage that feeds the pipeline ALU. It takes a fetched 32-bit MIPS instruction plus register-file operands and decodes the ALU control code. It selects forwarded or immediate operands and registers everything into the ID/EX pipeline register, with valid/stall/flush handling. It is the producer side of the ALU's `a`/`b`/`aluc` interface.

## Interface
- `FWD_EN_DEFAULT`, 1: reset value of the internal forwarding-enable bit; 0 forces register-file operands.
- `clock` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `inst` and operands are valid this cycle.
- `in_ready` out 1: the stage accepts an instruction this cycle; equals `~stall | flush`.
- `inst` in 32: instruction word.
- `rs_val`, `rt_val` in 32: register-file read data.
- `fwda`, `fwdb` in 2: operand source. 00 = regfile, 01 = EX result, 10 = MEM result, 11 = MEM load data.
- `ex_res`, `mem_res`, `mem_ld` in 32: forwarding sources.
- `stall` in 1: hold the EX register.
- `flush` in 1: kill the EX register contents (insert a bubble).
- `ex_valid` out 1; `ex_aluc` out 4; `ex_a`, `ex_b` out 32; `ex_rd` out 5; `ex_wreg` out 1; `ex_mem_rd` out 1; `ex_mem_wr` out 1; `ex_store` out 32.
- `ex_illegal` out 1: the issued slot held an unsupported opcode (macro-dependent).

## Operation
- The ALU code matches the ALU encoding:
  - ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010
  - LUI 0110, SLL 0011, SRL 0111, SRA 1111
- R-type (opcode 000000), by funct:
  - 100000/100001 → ADD; 100010/100011 → SUB
  - 100100 → AND; 100101 → OR; 100110 → XOR
  - 000000 → SLL; 000010 → SRL; 000011 → SRA
- I-type, by opcode:
  - 001000/001001 → ADD, sign-extended immediate
  - 001100/001101/001110 → AND/OR/XOR, zero-extended immediate
  - 001111 → LUI, zero-extended immediate
  - 100011 (lw) and 101011 (sw) → ADD, sign-extended immediate
- Operand A:
  - Shifts: `{27'b0, inst[10:6]}`.
  - Otherwise: forwarded rs.
- Operand B:
  - R-type: forwarded rt.
  - I-type: extended immediate.
- `ex_store` is forwarded rt (sw data).
- Destination and write enable:
  - Destination is rd for R-type, rt for I-type.
  - `ex_wreg` = 0 for sw, for illegal instructions, and whenever the destination is $0.
- `ex_mem_rd` = 1 for lw; `ex_mem_wr` = 1 for sw.
- The instruction word 0 (sll $0,$0,0) is a legal NOP with `ex_wreg` = 0.

## Timing
- Latency: 1 cycle. Decode is combinational and captured on the rising edge of `clock` into the EX register.
- Register update priority, highest first:
  1. `!resetn`: all outputs 0, including `ex_valid` and `ex_illegal`.
  2. `flush`: `ex_valid`, `ex_wreg`, `ex_mem_rd`, `ex_mem_wr`, `ex_illegal` ← 0; data fields are don't-care.
  3. `stall`: every EX field holds its value.
  4. Otherwise: load the decode result, with `ex_valid` ← `in_valid`.
- Flush and stall in the same cycle: flush wins, and `in_ready` = 1; the offered instruction is dropped, not captured.
- `in_valid` = 0 without stall or flush: a bubble is loaded, with all control bits 0.
- Reset asserted mid-stall clears the stage; the first valid issue after deassertion occurs on the first edge with `resetn` high.
- Forward selects are sampled in the same cycle as `inst`; no operand is re-read while stalled.

## Configuration
- `ID_ALU_ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode or funct issues with `ex_valid` = 1, `ex_illegal` = 1 and all write/memory controls 0.
  - `ex_aluc` is 0000 for that slot.
- Not defined:
  - An unsupported instruction issues as a bubble (`ex_valid` = 0).
  - `ex_illegal` is tied to 0.

## Structure
- Shared package `mips_pkg`:
  - ALU code constants (`ALU_ADD` … `ALU_SRA`).
  - Opcode and funct constants.
  - Forward-select constants.
- Sub-module `id_alu_decode`: purely combinational. Maps `inst` to aluc, immediate mode, shift select, destination select, wreg/mem_rd/mem_wr and legality.
- Top level holds the forwarding muxes and the EX register.

## Test plan
- Reset: hold `resetn` = 0, then release → every `ex_*` output is 0 and `in_ready` = 1.
- Decode sweep:
  - `addi $2,$1,-1` (0x2022FFFF), `rs_val` = 5 → next cycle `ex_aluc` = 0000, `ex_a` = 5, `ex_b` = 0xFFFFFFFF, `ex_rd` = 2, `ex_wreg` = 1.
  - `andi` with imm 0x8000 → `ex_b` = 0x00008000.
- Shifts:
  - `sra $3,$4,7` (0x000419C3), `rt_val` = 0x80000000 → `ex_aluc` = 1111, `ex_a` = 7, `ex_b` = 0x80000000.
  - `lui $5,0x1234` → `ex_aluc` = 0110, `ex_b` = 0x1234.
- Forwarding: `fwda` = 01 with `ex_res` = 0xAA, then `fwdb` = 11 with `mem_ld` = 0x55 → `ex_a` = 0xAA, then `ex_b` = 0x55; regfile values ignored.
- Stall/flush:
  - Stall for 3 cycles → EX fields constant and `in_ready` = 0.
  - Stall and flush together → `ex_valid` = 0 and `in_ready` = 1.
  - `sw` → `ex_wreg` = 0, `ex_mem_wr` = 1.
- Illegal: opcode 111111 → with the macro, `ex_valid` = 1 and `ex_illegal` = 1; without it, `ex_valid` = 0.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared ALU codes, MIPS opcode/funct and forward-select constants,
//            decode/EX-slot types and the operand forwarding mux helper.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_LD  = 2'b11;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2
    } imm_mode_e;

    typedef struct packed {
        logic [3:0] aluc;
        imm_mode_e  imm_mode;
        logic       shift;
        logic       dst_rt;
        logic       wreg;
        logic       mem_rd;
        logic       mem_wr;
        logic       legal;
    } decode_t;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wreg;
        logic        mem_rd;
        logic        mem_wr;
        logic [31:0] store;
    } ex_t;

    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] rf,
                                            input logic [31:0] ex,
                                            input logic [31:0] mem,
                                            input logic [31:0] ld);
        case (sel)
            FWD_EX:  fwd_mux = ex;
            FWD_MEM: fwd_mux = mem;
            FWD_LD:  fwd_mux = ld;
            default: fwd_mux = rf;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : id_alu_issue_if
// Brief    : ID/EX slot bus from the issue stage (master) to the ALU (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface id_alu_issue_if;
    logic        ex_valid;
    logic        ex_illegal;
    logic [3:0]  ex_aluc;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_rd;
    logic        ex_wreg;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [31:0] ex_store;

    modport master (
        output ex_valid, ex_illegal, ex_aluc, ex_a, ex_b, ex_rd,
               ex_wreg, ex_mem_rd, ex_mem_wr, ex_store
    );
    modport slave (
        input  ex_valid, ex_illegal, ex_aluc, ex_a, ex_b, ex_rd,
               ex_wreg, ex_mem_rd, ex_mem_wr, ex_store
    );
endinterface
`default_nettype wire

// File: rtl/id_alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : id_alu_decode
// Brief    : Combinational MIPS decode to ALU code, operand selects and
//            write/memory controls; unsupported encodings leave legal = 0.
// Revision : 1.0 - initial release
// ============================================================================
module id_alu_decode
    import mips_pkg::*;
(
    input  wire logic [5:0] op,
    input  wire logic [5:0] funct,
    input  wire logic [4:0] rt,
    input  wire logic [4:0] rd,
    output decode_t         dec
);

    logic [4:0] dest;

    always_comb begin
        dec          = '0;
        dec.imm_mode = IMM_NONE;
        if (op == OP_RTYPE) begin
            dec.legal = 1'b1;
            case (funct)
                F_ADD, F_ADDU: dec.aluc = ALU_ADD;
                F_SUB, F_SUBU: dec.aluc = ALU_SUB;
                F_AND:         dec.aluc = ALU_AND;
                F_OR:          dec.aluc = ALU_OR;
                F_XOR:         dec.aluc = ALU_XOR;
                F_SLL: begin dec.aluc = ALU_SLL; dec.shift = 1'b1; end
                F_SRL: begin dec.aluc = ALU_SRL; dec.shift = 1'b1; end
                F_SRA: begin dec.aluc = ALU_SRA; dec.shift = 1'b1; end
                default:       dec.legal = 1'b0;
            endcase
        end else begin
            dec.legal  = 1'b1;
            dec.dst_rt = 1'b1;
            case (op)
                OP_ADDI, OP_ADDIU: begin dec.aluc = ALU_ADD; dec.imm_mode = IMM_SEXT; end
                OP_ANDI: begin dec.aluc = ALU_AND; dec.imm_mode = IMM_ZEXT; end
                OP_ORI:  begin dec.aluc = ALU_OR;  dec.imm_mode = IMM_ZEXT; end
                OP_XORI: begin dec.aluc = ALU_XOR; dec.imm_mode = IMM_ZEXT; end
                OP_LUI:  begin dec.aluc = ALU_LUI; dec.imm_mode = IMM_ZEXT; end
                OP_LW: begin
                    dec.aluc = ALU_ADD; dec.imm_mode = IMM_SEXT; dec.mem_rd = 1'b1;
                end
                OP_SW: begin
                    dec.aluc = ALU_ADD; dec.imm_mode = IMM_SEXT; dec.mem_wr = 1'b1;
                end
                default: dec.legal = 1'b0;
            endcase
        end
        if (!dec.legal) begin
            dec.aluc   = ALU_ADD;
            dec.mem_rd = 1'b0;
            dec.mem_wr = 1'b0;
        end
        // Writes to $0 are architecturally discarded, so never request them.
        dest     = dec.dst_rt ? rt : rd;
        dec.wreg = dec.legal && !dec.mem_wr && (dest != 5'd0);
    end

endmodule
`default_nettype wire

// File: rtl/id_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : id_alu_issue
// Brief    : Decode/issue stage: forwarding muxes plus the ID/EX register
//            with stall/flush. Optional macro: ID_ALU_ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_alu_issue
    import mips_pkg::*;
#(
    parameter bit FWD_EN_DEFAULT = 1'b1
) (
    input  wire logic        clock,
    input  wire logic        resetn,
    input  wire logic        in_valid,
    output logic             in_ready,
    input  wire logic [31:0] inst,
    input  wire logic [31:0] rs_val,
    input  wire logic [31:0] rt_val,
    input  wire logic [1:0]  fwda,
    input  wire logic [1:0]  fwdb,
    input  wire logic [31:0] ex_res,
    input  wire logic [31:0] mem_res,
    input  wire logic [31:0] mem_ld,
    input  wire logic        stall,
    input  wire logic        flush,
    id_alu_issue_if.master   ex
);

    decode_t     dec;
    ex_t         issue;
    ex_t         ex_d, ex_q;
    logic        fwd_en_d, fwd_en_q;
    logic [31:0] rs_fwd, rt_fwd, imm;
    logic        unused_rs_field;

    // rs register number is consumed by the register file, not by this stage.
    assign unused_rs_field = ^inst[25:21];

    id_alu_decode u_decode (
        .op    (inst[31:26]),
        .funct (inst[5:0]),
        .rt    (inst[20:16]),
        .rd    (inst[15:11]),
        .dec   (dec)
    );

    always_comb begin
        rs_fwd = fwd_mux(fwd_en_q ? fwda : FWD_RF, rs_val, ex_res, mem_res, mem_ld);
        rt_fwd = fwd_mux(fwd_en_q ? fwdb : FWD_RF, rt_val, ex_res, mem_res, mem_ld);
        case (dec.imm_mode)
            IMM_SEXT: imm = {{16{inst[15]}}, inst[15:0]};
            IMM_ZEXT: imm = {16'b0, inst[15:0]};
            default:  imm = 32'b0;
        endcase

        issue        = '0;
        issue.aluc   = dec.aluc;
        issue.a      = dec.shift ? {27'b0, inst[10:6]} : rs_fwd;
        issue.b      = (dec.imm_mode == IMM_NONE) ? rt_fwd : imm;
        issue.rd     = dec.dst_rt ? inst[20:16] : inst[15:11];
        issue.store  = rt_fwd;
        issue.wreg   = in_valid & dec.wreg;
        issue.mem_rd = in_valid & dec.mem_rd;
        issue.mem_wr = in_valid & dec.mem_wr;
`ifdef ID_ALU_ILLEGAL_TRAP_EN
        issue.valid   = in_valid;
        issue.illegal = in_valid & ~dec.legal;
`else
        issue.valid   = in_valid & dec.legal;
        issue.illegal = 1'b0;
`endif
    end

    always_comb begin
        ex_d     = ex_q;
        fwd_en_d = fwd_en_q;
        if (flush) begin
            ex_d.valid   = 1'b0;
            ex_d.illegal = 1'b0;
            ex_d.wreg    = 1'b0;
            ex_d.mem_rd  = 1'b0;
            ex_d.mem_wr  = 1'b0;
        end else if (!stall) begin
            ex_d = issue;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ex_q     <= '0;
            fwd_en_q <= FWD_EN_DEFAULT;
        end else begin
            ex_q     <= ex_d;
            fwd_en_q <= fwd_en_d;
        end
    end

    assign in_ready      = ~stall | flush;
    assign ex.ex_valid   = ex_q.valid;
    assign ex.ex_illegal = ex_q.illegal;
    assign ex.ex_aluc    = ex_q.aluc;
    assign ex.ex_a       = ex_q.a;
    assign ex.ex_b       = ex_q.b;
    assign ex.ex_rd      = ex_q.rd;
    assign ex.ex_wreg    = ex_q.wreg;
    assign ex.ex_mem_rd  = ex_q.mem_rd;
    assign ex.ex_mem_wr  = ex_q.mem_wr;
    assign ex.ex_store   = ex_q.store;

endmodule
`default_nettype wire
